// File: rtl/mode_select_fsm_pkg.sv
// Shared mode constants, per-key debounce state encoding and the MODE step rule
// for the DE10-Lite mode selector.
package mode_select_fsm_pkg;

  localparam logic [1:0] MODE_ARITH   = 2'd0;
  localparam logic [1:0] MODE_LOGIC   = 2'd1;
  localparam logic [1:0] MODE_COMPARE = 2'd2;
  localparam logic [1:0] MODE_MAGIC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_e;

  // step[0] advances, step[1] goes back, both together force arithmetic mode.
  function automatic logic [1:0] mode_update(input logic [1:0] mode, input logic [1:0] step);
    logic [1:0] nxt;
    case (step)
      2'b01:   nxt = mode + 2'd1;
      2'b10:   nxt = mode - 2'd1;
      2'b11:   nxt = MODE_ARITH;
      default: nxt = mode;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mode_select_fsm_key_debouncer.sv
// One push button: two-flop synchronizer, press/release debounce FSM and
// hold-to-repeat timer, producing a registered one-cycle step pulse.
module key_debouncer
  import mode_select_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic step_o
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit               RPT_EN   = (REPEAT_CYCLES != 0);

  logic             sync1_q, sync2_q;
  logic             pressed;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             step_q, step_d;

  assign pressed = ~sync2_q;
  assign step_o  = step_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      rpt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        rpt_d = '0;
        if (pressed) begin
          state_d = DB_PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          rpt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_W'(1);
          rpt_d   = '0;
        end else if (RPT_EN) begin
          rpt_d = (rpt_q == RPT_LAST) ? '0 : rpt_q + 1'b1;
        end
      end
      DB_RELEASE: begin
        // A re-press inside the release window is bounce: resume holding without a step.
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
          rpt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d = 1'b0;
    if (state_q == DB_PRESS && pressed && cnt_q == DB_LAST) begin
      step_d = 1'b1;
    end
    if (RPT_EN && state_q == HELD && pressed && rpt_q == RPT_LAST) begin
      step_d = 1'b1;
    end
  end

endmodule

// File: rtl/mode_select_fsm.sv
// Debounced KEY-to-MODE selector: two independent key debouncers feed the 2-bit
// MODE register and a one-cycle change strobe.
module mode_select_fsm
  import mode_select_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  output logic [1:0] MODE,
  output logic       MODE_CHANGED,
  output logic [1:0] KEY_STEP
);

  logic [1:0] step;
  logic [1:0] mode_q, mode_d;
  logic       changed_q, changed_d;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk_i  (CLK),
      .rst_i  (RST),
      .key_n_i(KEY[k]),
      .step_o (step[k])
    );
  end

  always_comb begin
    mode_d    = mode_update(mode_q, step);
    changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q    <= MODE_ARITH;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      changed_q <= changed_d;
    end
  end

  assign MODE         = mode_q;
  assign MODE_CHANGED = changed_q;
  assign KEY_STEP     = step;

endmodule
